pulse_capture_ctrl: RTL and testbench



---
 rtl/pulse_capture_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pulse_capture_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_capture_ctrl.sv
// Multi-channel pulse capture: circular pre-trigger history, run-length trigger, post capture, word readout.
// Optional PULSE_CAPTURE_TIMESTAMP_EN prepends a two-word trigger timestamp header to each frame.
module pulse_capture_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                NUM_CH    = 4,
  parameter int                PRE_LEN   = 50,
  parameter int                POST_LEN  = 100,
  parameter logic [DATA_W-1:0] VALID_LO  = DATA_W'(32),
  parameter logic [DATA_W-1:0] VALID_HI  = DATA_W'(16'hF800),
  parameter int                VALID_RUN = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     frame_ready,
  output logic                     armed,
  output logic [15:0]              drop_cnt
);

  localparam int DEPTH = PRE_LEN + POST_LEN;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FC_W  = $clog2(PRE_LEN + 1);
  localparam int PC_W  = $clog2(POST_LEN + 1);
  localparam int RUN_W = $clog2(VALID_RUN + 1);
`ifdef PULSE_CAPTURE_TIMESTAMP_EN
  localparam int HDR_WORDS = 2;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int FRAME_WORDS = DEPTH * NUM_CH + HDR_WORDS;
  localparam int WC_W        = $clog2(FRAME_WORDS + 1);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(VALID_RUN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {FILL, ARMED, POST, READOUT} state_t;
  state_t state, state_nxt;

  logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_nxt, rd_ptr;
  logic [CH_W-1:0]  rd_ch;
  logic [WC_W-1:0]  word_cnt;
  logic [FC_W-1:0]  fill_cnt;
  logic [PC_W-1:0]  post_cnt;
  logic [RUN_W-1:0] run, run_nxt;
  logic             in_win, trig, wr_en, ld_rd, go_fill, ts_latch, rd_fire, in_hdr;
  logic [NUM_CH*DATA_W-1:0] vec_p0;
  logic [DATA_W-1:0]        word_p0;

  function automatic logic [DATA_W-1:0] ts_half(input logic [15:0] h);
    logic [DATA_W+15:0] ext;
    ext = {{DATA_W{1'b0}}, h};
    return ext[DATA_W-1:0];
  endfunction

  always_comb begin
    in_win = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sample_data[k*DATA_W +: DATA_W] >= VALID_LO &&
          sample_data[k*DATA_W +: DATA_W] <  VALID_HI)
        in_win = 1'b1;
    end
  end

  assign run_nxt = in_win ? ((run == RUN_MAX) ? run : run + 1'b1) : '0;
  // Covers both "reaches VALID_RUN now" and "already saturated and still in-window".
  assign trig    = in_win && (run_nxt == RUN_MAX);
  assign wr_nxt  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
  assign rd_fire = (state == READOUT) && rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    ld_rd     = 1'b0;
    go_fill   = 1'b0;
    ts_latch  = 1'b0;
    case (state)
      FILL: if (sample_valid) begin
        wr_en = 1'b1;
        if (fill_cnt == FC_W'(PRE_LEN - 1)) state_nxt = ARMED;
      end
      ARMED: if (sample_valid) begin
        wr_en = 1'b1;
        if (trig) begin
          ts_latch = 1'b1;
          if (POST_LEN == 1) begin
            state_nxt = READOUT;
            ld_rd     = 1'b1;
          end else begin
            state_nxt = POST;
          end
        end
      end
      POST: if (sample_valid) begin
        wr_en = 1'b1;
        if (post_cnt == PC_W'(POST_LEN - 1)) begin
          state_nxt = READOUT;
          ld_rd     = 1'b1;
        end
      end
      READOUT: if (rd_fire && word_cnt == WC_LAST) begin
        state_nxt = FILL;
        go_fill   = 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign armed       = (state == ARMED);
  assign frame_ready = (state == READOUT);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_data;
  end

`ifdef PULSE_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_lat;
  assign in_hdr = (word_cnt < WC_W'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      if (sample_valid) ts_cnt <= ts_cnt + 32'd1;
      // Latched value includes the trigger vector's own increment.
      if (ts_latch)     ts_lat <= ts_cnt + 32'd1;
    end
  end
`else
  assign in_hdr = 1'b0;
`endif

  // Stage p0: combinational word select from the frozen buffer or header.
  always_comb begin
    vec_p0  = mem[rd_ptr];
    word_p0 = vec_p0[rd_ch*DATA_W +: DATA_W];
`ifdef PULSE_CAPTURE_TIMESTAMP_EN
    if (in_hdr) word_p0 = (word_cnt == '0) ? ts_half(ts_lat[31:16]) : ts_half(ts_lat[15:0]);
`endif
  end

  // Stage p1: registered readout word and all counters/pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_ch    <= '0;
      word_cnt <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      run      <= '0;
      drop_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && (word_cnt == WC_LAST);
      if (rd_fire) rd_data <= word_p0;

      if (wr_en) wr_ptr <= wr_nxt;
      if (sample_valid && state != READOUT) run <= run_nxt;
      if (sample_valid && state == FILL) fill_cnt <= fill_cnt + 1'b1;
      if (ts_latch) post_cnt <= PC_W'(1);
      else if (sample_valid && state == POST) post_cnt <= post_cnt + 1'b1;
      if (sample_valid && state == READOUT && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      if (ld_rd) begin
        rd_ptr   <= wr_nxt;
        rd_ch    <= '0;
        word_cnt <= '0;
      end else if (rd_fire) begin
        word_cnt <= word_cnt + 1'b1;
        if (!in_hdr) begin
          if (rd_ch == CH_LAST) begin
            rd_ch  <= '0;
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
          end else begin
            rd_ch <= rd_ch + 1'b1;
          end
        end
      end

      if (go_fill) begin
        fill_cnt <= '0;
        run      <= '0;
        post_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_capture_ctrl.sv
// Directed bench for pulse_capture_ctrl with NUM_CH=2, PRE_LEN=4, POST_LEN=4, VALID_RUN=3.
module tb_pulse_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        frame_ready;
  logic        armed;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PULSE_CAPTURE_TIMESTAMP_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  pulse_capture_ctrl #(
    .DATA_W(16), .NUM_CH(2), .PRE_LEN(4), .POST_LEN(4),
    .VALID_LO(16'd32), .VALID_HI(16'hF800), .VALID_RUN(3)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .frame_ready(frame_ready), .armed(armed), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c0, input logic [15:0] c1);
    sample_data  = {c1, c0};
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w;
    int          total;
    int          v;
    rst = 1'b1; sample_valid = 1'b0; sample_data = '0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_armed", armed, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chk("fill_rdreq_ignored", rd_valid, 0);

    // Fill: armed only after the 4th vector
    repeat (3) push(16'd100, 16'd100);
    chk("fill3_armed", armed, 0);
    push(16'd100, 16'd100);
    chk("fill4_armed", armed, 1);
    chk("fill4_frame_ready", frame_ready, 0);

    // Run broken by an out-of-window vector
    do_reset();
    repeat (4) push(16'd10, 16'd10);
    chk("runB_armed", armed, 1);
    repeat (2) push(16'd100, 16'd100);
    push(16'd10, 16'd10);
    chk("runB_break_armed", armed, 1);
    repeat (2) push(16'd100, 16'd100);
    chk("runB_two_armed", armed, 1);
    push(16'd100, 16'd100);
    chk("runB_trig_armed", armed, 0);
    repeat (2) push(16'd100, 16'd100);
    chk("runB_post3_ready", frame_ready, 0);
    push(16'd100, 16'd100);
    chk("runB_post4_ready", frame_ready, 1);

    // Window bounds: 31 and F800 are out, F7FF is in
    do_reset();
    repeat (14) push(16'd31, 16'hF800);
    chk("bound_out_armed", armed, 1);
    chk("bound_out_ready", frame_ready, 0);
    repeat (2) push(16'd31, 16'hF7FF);
    chk("bound_in2_armed", armed, 1);
    push(16'd31, 16'hF7FF);
    chk("bound_in3_armed", armed, 0);

    // Frame capture: vectors 1..12, trigger on vector 9
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      push(16'(n), (n <= 6) ? 16'(n) : 16'(n + 100));
      if (n == 8) chk("frame_v8_armed", armed, 1);
      if (n == 9) chk("frame_v9_armed", armed, 0);
    end
    chk("frame_ready_set", frame_ready, 1);

    repeat (5) push(16'hDEAD, 16'hBEEF);
    chk("drop5", drop_cnt, 5);
    chk("drop_ready_held", frame_ready, 1);

    total = 16 + HDR;
    for (int i = 0; i < total; i++) begin
      rd_req = 1'b1;
      if (i == total - 1) begin
        sample_data  = 32'h1234_5678;
        sample_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      if (i < HDR) begin
        exp_w = (i == 0) ? 16'h0000 : 16'h0009;
      end else begin
        v     = 5 + (i - HDR) / 2;
        exp_w = (((i - HDR) % 2) == 0) ? 16'(v) : ((v <= 6) ? 16'(v) : 16'(v + 100));
      end
      chk($sformatf("rd_valid_%0d", i), rd_valid, 1);
      chk($sformatf("rd_data_%0d", i), rd_data, exp_w);
      chk($sformatf("rd_last_%0d", i), rd_last, (i == total - 1) ? 1 : 0);
    end
    rd_req = 1'b0;
    chk("post_frame_ready", frame_ready, 0);
    chk("drop_final_req", drop_cnt, 6);

    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chk("rdreq_after_last", rd_valid, 0);

    repeat (3) push(16'd10, 16'd10);
    chk("refill3_armed", armed, 0);
    push(16'd10, 16'd10);
    chk("refill4_armed", armed, 1);

    // Second frame, aborted by async reset mid-readout
    repeat (3) push(16'd200, 16'd200);
    chk("abort_trig_armed", armed, 0);
    repeat (3) push(16'd200, 16'd200);
    chk("abort_ready", frame_ready, 1);
    rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_mid_valid", rd_valid, 1);
    chk("abort_drop_before", drop_cnt, 6);
    #2 rst = 1'b1;
    #1;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_data", rd_data, 0);
    chk("abort_rd_last", rd_last, 0);
    chk("abort_frame_ready", frame_ready, 0);
    chk("abort_armed", armed, 0);
    chk("abort_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    rd_req = 1'b0;
    repeat (3) push(16'd10, 16'd10);
    chk("abort_fill3_armed", armed, 0);
    push(16'd10, 16'd10);
    chk("abort_fill4_armed", armed, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
